// File: rtl/imm_encoder_if.sv
// Valid/ready bus for the immediate encoder: request side (in_*) and result side (out_*).
// master drives requests and consumes results; slave is the encoder.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_extop;
    logic [31:0] in_base;
    logic [31:0] in_imm;
    logic        in_sra;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [1:0]  out_err_code;

    modport master (
        output in_valid, in_extop, in_base, in_imm, in_sra, out_ready,
        input  in_ready, out_valid, out_instr, out_err, out_err_code
    );

    modport slave (
        input  in_valid, in_extop, in_base, in_imm, in_sra, out_ready,
        output in_ready, out_valid, out_instr, out_err, out_err_code
    );
endinterface

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: S1 range/alignment-checks the immediate, S2 scatters it
// into the format's instruction fields (or substitutes NOP_WORD on error).
module imm_encoder #(
    parameter int unsigned ERR_CNT_W = 8,
    parameter logic [31:0] NOP_WORD  = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imm_encoder_if.slave         bus,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam logic [2:0] EXT_I    = 3'b000;
    localparam logic [2:0] EXT_U    = 3'b001;
    localparam logic [2:0] EXT_S    = 3'b010;
    localparam logic [2:0] EXT_B    = 3'b011;
    localparam logic [2:0] EXT_J    = 3'b100;
    localparam logic [2:0] EXT_SH   = 3'b101;
    localparam logic [2:0] EXT_ILL  = 3'b110;
    localparam logic [2:0] EXT_NONE = 3'b111;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_RANGE   = 2'b01;
    localparam logic [1:0] ERR_ALIGN   = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    logic        s1_valid;
    logic [2:0]  s1_extop;
    logic [31:0] s1_base;
    logic [31:0] s1_imm;
    logic        s1_sra;
    logic        s1_err;
    logic [1:0]  s1_code;

    logic        s2_valid;
    logic [31:0] s2_instr;
    logic        s2_err;
    logic [1:0]  s2_code;

    logic        s2_load;
    logic        accept;
    logic [1:0]  chk_code;
    logic [31:0] pack_word;

    // in_ready looks through S2 to out_ready so a full pipe can shift without a bubble
    assign s2_load      = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_load;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        chk_code = ERR_OK;
        case (bus.in_extop)
            EXT_I, EXT_S: begin
                if (!((&bus.in_imm[31:11]) || !(|bus.in_imm[31:11])))
                    chk_code = ERR_RANGE;
            end
            EXT_B: begin
                if (bus.in_imm[0])
                    chk_code = ERR_ALIGN;
                else if (!((&bus.in_imm[31:12]) || !(|bus.in_imm[31:12])))
                    chk_code = ERR_RANGE;
            end
            EXT_J: begin
                if (bus.in_imm[0])
                    chk_code = ERR_ALIGN;
                else if (!((&bus.in_imm[31:20]) || !(|bus.in_imm[31:20])))
                    chk_code = ERR_RANGE;
            end
            EXT_U: begin
                if (|bus.in_imm[11:0])
                    chk_code = ERR_RANGE;
            end
            EXT_SH: begin
                if (|bus.in_imm[31:5])
                    chk_code = ERR_RANGE;
            end
            EXT_NONE: begin
                if (|bus.in_imm)
                    chk_code = ERR_RANGE;
            end
            EXT_ILL: chk_code = ERR_ILLEGAL;
            default: chk_code = ERR_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_extop <= '0;
            s1_base  <= '0;
            s1_imm   <= '0;
            s1_sra   <= 1'b0;
            s1_err   <= 1'b0;
            s1_code  <= ERR_OK;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (accept) begin
                s1_extop <= bus.in_extop;
                s1_base  <= bus.in_base;
                s1_imm   <= bus.in_imm;
                s1_sra   <= bus.in_sra;
                s1_err   <= (chk_code != ERR_OK);
                s1_code  <= chk_code;
            end
        end
    end

    always_comb begin
        pack_word = s1_base;
        case (s1_extop)
            EXT_I:    pack_word = {s1_imm[11:0], s1_base[19:0]};
            EXT_U:    pack_word = {s1_imm[31:12], s1_base[11:0]};
            EXT_S:    pack_word = {s1_imm[11:5], s1_base[24:12], s1_imm[4:0], s1_base[6:0]};
            EXT_B:    pack_word = {s1_imm[12], s1_imm[10:5], s1_base[24:12],
                                   s1_imm[4:1], s1_imm[11], s1_base[6:0]};
            EXT_J:    pack_word = {s1_imm[20], s1_imm[10:1], s1_imm[11],
                                   s1_imm[19:12], s1_base[11:0]};
            EXT_SH:   pack_word = {1'b0, s1_sra, 5'b00000, s1_imm[4:0], s1_base[19:0]};
            EXT_NONE: pack_word = s1_base;
            default:  pack_word = s1_base;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_instr <= '0;
            s2_err   <= 1'b0;
            s2_code  <= ERR_OK;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_instr <= s1_err ? NOP_WORD : pack_word;
                s2_err   <= s1_err;
                s2_code  <= s1_code;
            end
        end
    end

    assign bus.out_valid    = s2_valid;
    assign bus.out_instr    = s2_instr;
    assign bus.out_err      = s2_err;
    assign bus.out_err_code = s2_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (s2_valid && bus.out_ready && s2_err && (err_count != '1)) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// Randomized and directed bench for imm_encoder; outputs are scored against a
// range/field model computed with plain arithmetic.
module tb_imm_encoder;
    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] err_count;

    int unsigned n_vec = 0;
    int unsigned n_mis = 0;
    int unsigned n_acc = 0;
    int unsigned n_out = 0;
    int unsigned exp_errcnt = 0;
    exp_t        sb[$];
    bit          rand_done;

    imm_encoder_if bus();

    imm_encoder #(.ERR_CNT_W(8), .NOP_WORD(32'h00000013)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_model(input logic [2:0] ext, input logic [31:0] base,
                                       input logic [31:0] imm, input logic sra);
        exp_t    r;
        longint  s;
        s = longint'($signed(imm));
        r.code = 2'd0;
        case (ext)
            3'd6: r.code = 2'd3;
            3'd0, 3'd2: if (s < -2048 || s > 2047) r.code = 2'd1;
            3'd3: if (imm % 2 != 0) r.code = 2'd2;
                  else if (s < -4096 || s > 4095) r.code = 2'd1;
            3'd4: if (imm % 2 != 0) r.code = 2'd2;
                  else if (s < -1048576 || s > 1048575) r.code = 2'd1;
            3'd1: if (imm % 4096 != 0) r.code = 2'd1;
            3'd5: if (imm > 31) r.code = 2'd1;
            default: if (imm != 0) r.code = 2'd1;
        endcase
        r.err = (r.code != 2'd0);
        case (ext)
            3'd0: r.instr = (base & 32'h000FFFFF) | ((imm & 32'hFFF) << 20);
            3'd1: r.instr = (base & 32'h00000FFF) | (imm & 32'hFFFFF000);
            3'd2: r.instr = (base & 32'h01FFF07F) | (((imm >> 5) & 32'h7F) << 25)
                          | ((imm & 32'h1F) << 7);
            3'd3: r.instr = (base & 32'h01FFF07F) | (((imm >> 12) & 32'h1) << 31)
                          | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                          | (((imm >> 11) & 32'h1) << 7);
            3'd4: r.instr = (base & 32'h00000FFF) | (((imm >> 20) & 32'h1) << 31)
                          | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
                          | (imm & 32'h000FF000);
            3'd5: r.instr = (base & 32'h000FFFFF) | (32'(sra) << 30) | ((imm & 32'h1F) << 20);
            default: r.instr = base;
        endcase
        if (r.err) r.instr = 32'h00000013;
        return r;
    endfunction

    // Scoreboard: output handshake retires the oldest accepted word
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("out_unexpected", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_instr", bus.out_instr, e.instr);
                    check("out_err", 32'(bus.out_err), 32'(e.err));
                    check("out_code", 32'(bus.out_err_code), 32'(e.code));
                    if (e.err && exp_errcnt < 255) exp_errcnt++;
                end
                n_out++;
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(ref_model(bus.in_extop, bus.in_base, bus.in_imm, bus.in_sra));
                n_acc++;
            end
        end
    end

    task automatic send(input logic [2:0] ext, input logic [31:0] base,
                        input logic [31:0] imm, input logic sra);
        int unsigned waited = 0;
        bus.in_valid = 1'b1;
        bus.in_extop = ext;
        bus.in_base  = base;
        bus.in_imm   = imm;
        bus.in_sra   = sra;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 500) begin
                check("send_timeout", waited, 0);
                break;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Single word through an idle pipe with out_ready high
    task automatic run_one(input logic [2:0] ext, input logic [31:0] base, input logic [31:0] imm,
                           input logic sra, input logic [31:0] ei, input logic ee,
                           input logic [1:0] ec);
        bus.out_ready = 1'b1;
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_extop = ext;
        bus.in_base  = base;
        bus.in_imm   = imm;
        bus.in_sra   = sra;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("lat_early", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_valid", 32'(bus.out_valid), 32'd1);
        check("dir_instr", bus.out_instr, ei);
        check("dir_err", 32'(bus.out_err), 32'(ee));
        check("dir_code", 32'(bus.out_err_code), 32'(ec));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int unsigned n = 0;
        bus.out_ready = 1'b1;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 1000) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        check("drain_empty", 32'(bus.out_valid), 32'd0);
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0: v = $urandom;
            1: v = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: v = 32'd1 << $urandom_range(0, 31);
            3: v = (32'd1 << $urandom_range(0, 31)) - 32'd1;
            default: v = 32'($urandom_range(0, 40));
        endcase
        if ($urandom_range(0, 1) == 1) v = v & ~32'h1;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n0;
        int unsigned o0;
        bus.in_valid  = 1'b0;
        bus.in_extop  = 3'd0;
        bus.in_base   = 32'd0;
        bus.in_imm    = 32'd0;
        bus.in_sra    = 1'b0;
        bus.out_ready = 1'b1;

        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_out_err", 32'(bus.out_err), 32'd0);
        check("rst_out_code", 32'(bus.out_err_code), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        run_one(3'b000, 32'h00000093, 32'hFFFFFFFF, 1'b0, 32'hFFF00093, 1'b0, 2'b00);
        run_one(3'b011, 32'h00000063, 32'h00000008, 1'b0, 32'h00000463, 1'b0, 2'b00);
        run_one(3'b100, 32'h0000006F, 32'hFFFFFFFC, 1'b0, 32'hFFDFF06F, 1'b0, 2'b00);
        run_one(3'b001, 32'h000000B7, 32'h12345000, 1'b0, 32'h123450B7, 1'b0, 2'b00);
        run_one(3'b101, 32'h0000D093, 32'h00000003, 1'b1, 32'h4030D093, 1'b0, 2'b00);

        run_one(3'b011, 32'h00000063, 32'h00000005, 1'b0, 32'h00000013, 1'b1, 2'b10);
        run_one(3'b000, 32'h00000093, 32'h00000800, 1'b0, 32'h00000013, 1'b1, 2'b01);
        run_one(3'b110, 32'h00000093, 32'h00000000, 1'b0, 32'h00000013, 1'b1, 2'b11);
        check("err_count_3", 32'(err_count), 32'd3);

        for (int i = 0; i < 300; i++) send(3'b110, $urandom, 32'd0, 1'b0);
        drain();
        check("err_count_sat", 32'(err_count), 32'd255);

        // Backpressure: consumer stalls while five words stream in
        n0 = n_acc;
        o0 = n_out;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(3'($urandom_range(0, 5)), $urandom, 32'(i * 4), 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready", 32'(bus.in_ready), 32'd0);
                check("bp_accepts", n_acc - n0, 32'd2);
                repeat (2) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_out_count", n_out - o0, 32'd5);

        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send(3'($urandom_range(0, 7)), $urandom, rand_imm(), 1'($urandom_range(0, 1)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
        check("rand_err_count", 32'(err_count), 32'(exp_errcnt));

        // Reset with two words buffered behind a stalled consumer
        bus.out_ready = 1'b0;
        send(3'b000, 32'h00000093, 32'h00000001, 1'b0);
        send(3'b011, 32'h00000063, 32'h00000003, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_instr", bus.out_instr, 32'd0);
        check("mid_rst_err_count", 32'(err_count), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        sb.delete();
        exp_errcnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_one(3'b000, 32'h00000093, 32'hFFFFFFFF, 1'b0, 32'hFFF00093, 1'b0, 2'b00);
        run_one(3'b111, 32'h00000033, 32'h00000004, 1'b0, 32'h00000013, 1'b1, 2'b01);
        check("post_rst_err_count", 32'(err_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
